// File: rtl/dec_scan_reg.sv
// Registered N-to-2^N one-hot decoder with latched DECODE and auto-stepping SCAN modes.
// Optional macro DEC_ACTIVE_LOW_EN inverts d_out (selected line low, idle lines high).
module dec_scan_reg #(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DIV   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    load,
    input  logic [SEL_W-1:0]        sel_in,
    output logic [(2**SEL_W)-1:0]   d_out,
    output logic [SEL_W-1:0]        sel_cur,
    output logic                    wrap
);

    localparam int unsigned N_OUT   = 2 ** SEL_W;
    localparam int unsigned PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);
    localparam logic [SEL_W-1:0]   IDX_MAX   = SEL_W'(N_OUT - 1);
`ifdef DEC_ACTIVE_LOW_EN
    localparam logic [N_OUT-1:0]   OFF_PAT   = '1;
`else
    localparam logic [N_OUT-1:0]   OFF_PAT   = '0;
`endif

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DECODE_HOLD,
        ST_SCAN_DWELL
    } state_e;

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     index_q, index_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 mode_q,  mode_d;
    logic                 wrap_q,  wrap_d;
    logic [N_OUT-1:0]     d_out_q, d_out_d;

    logic                 step_c;
    logic                 mode_chg_c;
    logic [PRESC_W-1:0]   presc_eff_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            index_q <= '0;
            presc_q <= '0;
            mode_q  <= 1'b0;
            wrap_q  <= 1'b0;
            d_out_q <= OFF_PAT;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            presc_q <= presc_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
            d_out_q <= d_out_d;
        end
    end

    // Next-state: load beats step; a mode change restarts the dwell from zero
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        presc_d     = presc_q;
        mode_d      = mode_q;
        wrap_d      = 1'b0;
        d_out_d     = d_out_q;
        step_c      = 1'b0;
        mode_chg_c  = 1'b0;
        presc_eff_c = presc_q;

        if (en) begin
            mode_d      = mode;
            mode_chg_c  = (mode != mode_q);
            presc_eff_c = mode_chg_c ? '0 : presc_q;

            if (mode) begin
                state_d = ST_SCAN_DWELL;
                if (load) begin
                    index_d = sel_in;
                    presc_d = '0;
                end else if (presc_eff_c == PRESC_MAX) begin
                    step_c  = 1'b1;
                    presc_d = '0;
                    index_d = index_q + SEL_W'(1);
                end else begin
                    presc_d = presc_eff_c + PRESC_W'(1);
                end
            end else begin
                presc_d = '0;
                if (load) begin
                    index_d = sel_in;
                    state_d = ST_DECODE_HOLD;
                end else if (state_q != ST_OFF) begin
                    state_d = ST_DECODE_HOLD;
                end
            end

            wrap_d  = step_c && (index_q == IDX_MAX);
            d_out_d = ((state_d != ST_OFF) ? (N_OUT'(1) << index_d) : '0) ^ OFF_PAT;
        end
    end

    assign d_out   = d_out_q;
    assign sel_cur = index_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_dec_scan_reg.sv
// Directed self-checking bench for dec_scan_reg (SEL_W=2/DIV=4 and SEL_W=3/DIV=1 instances).
module tb_dec_scan_reg;

`ifdef DEC_ACTIVE_LOW_EN
    localparam bit AL = 1'b1;
`else
    localparam bit AL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, mode, load;
    logic [1:0] sel_in;
    logic [3:0] d_out;
    logic [1:0] sel_cur;
    logic       wrap;

    logic       rst_b, en_b, mode_b, load_b;
    logic [2:0] sel_in_b;
    logic [7:0] d_out_b;
    logic [2:0] sel_cur_b;
    logic       wrap_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dec_scan_reg #(.SEL_W(2), .DIV(4)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .sel_in(sel_in), .d_out(d_out), .sel_cur(sel_cur), .wrap(wrap)
    );

    dec_scan_reg #(.SEL_W(3), .DIV(1)) u_dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .load(load_b),
        .sel_in(sel_in_b), .d_out(d_out_b), .sel_cur(sel_cur_b), .wrap(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh4(input int i);
        logic [3:0] v;
        v = 4'(1) << i;
        return v ^ {4{AL}};
    endfunction

    function automatic logic [7:0] oh8(input int i);
        logic [7:0] v;
        v = 8'(1) << i;
        return v ^ {8{AL}};
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel_in = 2'd0;
        rst_b = 1'b1; en_b = 1'b0; mode_b = 1'b0; load_b = 1'b0; sel_in_b = 3'd0;

        // Reset, then release with en=0 and verify hold
        tick(); tick();
        check("rst_dout", 32'(d_out), 32'({4{AL}}));
        check("rst_sel", 32'(sel_cur), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("frz_dout", 32'(d_out), 32'({4{AL}}));
        check("frz_sel", 32'(sel_cur), 32'd0);

        // DECODE loads on consecutive edges, then hold
        en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load = 1'b1; sel_in = 2'(i);
            tick();
            check($sformatf("dec_dout%0d", i), 32'(d_out), 32'(oh4(i)));
            check($sformatf("dec_sel%0d", i), 32'(sel_cur), 32'(i));
            check($sformatf("dec_wrap%0d", i), 32'(wrap), 32'd0);
        end
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("dec_hold%0d", i), 32'(d_out), 32'(oh4(3)));
        end

        // SCAN from reset
        rst = 1'b1; tick(); rst = 1'b0;
        check("scan_rst", 32'(d_out), 32'({4{AL}}));
        mode = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("scan_dout_e%0d", k), 32'(d_out), 32'(oh4((k / 4) % 4)));
            check($sformatf("scan_wrap_e%0d", k), 32'(wrap), 32'(k == 16));
        end
        tick();
        check("scan_wrap_e17", 32'(wrap), 32'd0);

        // Advance to index 3, prescaler 3 (edge 31)
        for (int k = 18; k <= 31; k++) tick();
        check("pre_load_sel", 32'(sel_cur), 32'd3);
        load = 1'b1; sel_in = 2'd2;
        tick();
        load = 1'b0;
        check("ld_dout", 32'(d_out), 32'(oh4(2)));
        check("ld_sel", 32'(sel_cur), 32'd2);
        check("ld_nowrap", 32'(wrap), 32'd0);
        tick(); tick(); tick();
        check("ld_dwell", 32'(d_out), 32'(oh4(2)));
        tick();
        check("ld_step", 32'(d_out), 32'(oh4(3)));

        // Freeze mid-dwell delays the step by 3 edges
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("frz_wrap%0d", i), 32'(wrap), 32'd0);
        end
        en = 1'b1;
        tick(); tick();
        check("frz_nostep", 32'(d_out), 32'(oh4(3)));
        tick();
        check("frz_step", 32'(d_out), 32'(oh4(0)));
        check("frz_stepwrap", 32'(wrap), 32'd1);

        // Reset mid-scan at index 2
        for (int i = 0; i < 8; i++) tick();
        check("mid_sel", 32'(sel_cur), 32'd2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_dout", 32'(d_out), 32'({4{AL}}));
        check("mid_rst_sel", 32'(sel_cur), 32'd0);
        tick();
        check("restart_dout", 32'(d_out), 32'(oh4(0)));
        tick(); tick(); tick();
        check("restart_step", 32'(d_out), 32'(oh4(1)));

        // SEL_W=3, DIV=1 scan
        check("b_rst_dout", 32'(d_out_b), 32'({8{AL}}));
        rst_b = 1'b0; en_b = 1'b1; mode_b = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("b_dout_e%0d", k), 32'(d_out_b), 32'(oh8(k % 8)));
            check($sformatf("b_wrap_e%0d", k), 32'(wrap_b), 32'((k % 8) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
